// File: rtl/ram_bwe_pipe_tech.sv
// ram_bwe_pipe_tech: lane-write-enable single-port cache RAM with valid/ready channels, init sweep and 2-entry response buffer
//   i_clk, i_nrst (async, active low), i_clear (restart sweep), o_init_done
//   request : i_req_valid/o_req_ready, i_req_write, i_req_addr, i_req_wstrb, i_req_wdata
//   response: o_resp_valid/i_resp_ready, o_resp_write, o_resp_rdata (0 for writes)
//   ram_tech: one synchronous lane RAM, read data registered one cycle after the address
module ram_tech #(
    parameter int abits = 6,
    parameter int dbits = 8
) (
    input  logic             clk,
    input  logic [abits-1:0] addr,
    input  logic             wena,
    input  logic [dbits-1:0] wdata,
    output logic [dbits-1:0] rdata
);
    logic [dbits-1:0] mem [2**abits];
    always_ff @(posedge clk) begin
        if (wena) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

module ram_bwe_pipe_tech #(
    parameter int                  abits    = 6,
    parameter int                  dbits    = 128,
    parameter int                  lanebits = 8,
    parameter logic [lanebits-1:0] initval  = '0
) (
    input  logic                      i_clk,
    input  logic                      i_nrst,
    input  logic                      i_clear,
    output logic                      o_init_done,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_write,
    input  logic [abits-1:0]          i_req_addr,
    input  logic [dbits/lanebits-1:0] i_req_wstrb,
    input  logic [dbits-1:0]          i_req_wdata,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic                      o_resp_write,
    output logic [dbits-1:0]          o_resp_rdata
);
    localparam int nlanes = dbits / lanebits;
    typedef enum logic {INIT, READY} state_t;
    state_t           state, state_nxt;
    logic [abits-1:0] cnt_init, ram_addr;
    logic             clear_pend, s1_valid, s1_write;
    logic [1:0]       buf_cnt;
    logic [2:0]       occ;
    logic             buf_wp, buf_rp;
    logic             buf_write [2];
    logic [dbits-1:0] buf_data [2];
    logic [dbits-1:0] ram_rdata;
    logic             init_wr, accept, wr_acc, pop, buf_pop, push;

    assign init_wr      = state == INIT;
    assign o_init_done  = state == READY;
    // occupancy after this edge, counting the S1 entry that will land in the buffer
    assign occ          = {1'b0, buf_cnt} + {2'b0, s1_valid} - {2'b0, pop};
    assign o_req_ready  = o_init_done && !clear_pend && occ < 3'd2;
    assign accept       = i_req_valid && o_req_ready;
    assign wr_acc       = accept && i_req_write;
    assign ram_addr     = init_wr ? cnt_init : i_req_addr;
    // with an empty buffer the S1 stage is presented directly as the head
    assign o_resp_valid = buf_cnt != 2'd0 || s1_valid;
    assign o_resp_write = buf_cnt != 2'd0 ? buf_write[buf_rp] : s1_valid && s1_write;
    assign o_resp_rdata = buf_cnt != 2'd0 ? buf_data[buf_rp] :
                          (s1_valid && !s1_write) ? ram_rdata : '0;
    assign pop          = o_resp_valid && i_resp_ready;
    assign buf_pop      = pop && buf_cnt != 2'd0;
    assign push         = s1_valid && !(buf_cnt == 2'd0 && pop);

    for (genvar i = 0; i < nlanes; i++) begin : g_lane
        ram_tech #(.abits(abits), .dbits(lanebits)) u_ram (
            .clk   (i_clk),
            .addr  (ram_addr),
            .wena  (init_wr || (wr_acc && i_req_wstrb[i])),
            .wdata (init_wr ? initval : i_req_wdata[i*lanebits +: lanebits]),
            .rdata (ram_rdata[i*lanebits +: lanebits])
        );
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT) state_nxt = (!i_clear && &cnt_init) ? READY : INIT;
        else if (clear_pend) state_nxt = INIT;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state      <= INIT;
            cnt_init   <= '0;
            clear_pend <= 1'b0;
            s1_valid   <= 1'b0;
            s1_write   <= 1'b0;
            buf_cnt    <= 2'd0;
            buf_wp     <= 1'b0;
            buf_rp     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt_init   <= (init_wr && !i_clear) ? cnt_init + 1'b1 : '0;
            clear_pend <= o_init_done && i_clear && !clear_pend;
            s1_valid   <= accept;
            s1_write   <= i_req_write;
            buf_cnt    <= buf_cnt + {1'b0, push} - {1'b0, buf_pop};
            buf_wp     <= buf_wp ^ push;
            buf_rp     <= buf_rp ^ buf_pop;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_write[buf_wp] <= s1_write;
            buf_data[buf_wp]  <= s1_write ? '0 : ram_rdata;
        end
    end

    assert property (@(posedge i_clk) disable iff (!i_nrst) !(s1_valid && buf_cnt == 2'd2));
endmodule

// File: tb/tb_ram_bwe_pipe_tech.sv
// tb_ram_bwe_pipe_tech: directed bench for ram_bwe_pipe_tech (abits=4, dbits=32, lanebits=8, initval=8'h5A)
module tb_ram_bwe_pipe_tech;
    logic        i_clk = 1'b0;
    logic        i_nrst, i_clear, i_req_valid, i_req_write, i_resp_ready;
    logic [3:0]  i_req_addr, i_req_wstrb;
    logic [31:0] i_req_wdata;
    logic        o_init_done, o_req_ready, o_resp_valid, o_resp_write;
    logic [31:0] o_resp_rdata;
    int          checks = 0;
    int          errors = 0;

    ram_bwe_pipe_tech #(.abits(4), .dbits(32), .lanebits(8), .initval(8'h5A)) dut (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_clear      (i_clear),
        .o_init_done  (o_init_done),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_write  (i_req_write),
        .i_req_addr   (i_req_addr),
        .i_req_wstrb  (i_req_wstrb),
        .i_req_wdata  (i_req_wdata),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_write (o_resp_write),
        .o_resp_rdata (o_resp_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'h10203040 + 32'h01010101 * k[31:0];
    endfunction

    task automatic drive(input logic v, input logic w, input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
        i_req_valid = v;
        i_req_write = w;
        i_req_addr  = a;
        i_req_wstrb = s;
        i_req_wdata = d;
    endtask

    task automatic wait_sweep(input string tag);
        repeat (15) tick();
        chk({tag, "_busy"}, o_init_done, 1'b0);
        tick();
        chk({tag, "_done"}, o_init_done, 1'b1);
    endtask

    task automatic burst(input logic wr, input logic fresh);
        for (int k = 0; k <= 16; k++) begin
            drive(k < 16, wr, 4'(k), 4'hF, pat(k));
            #1;
            if (k < 16) chk("burst_ready", o_req_ready, 1'b1);
            if (k > 0) begin
                chk("burst_valid", o_resp_valid, 1'b1);
                chk("burst_write", o_resp_write, wr);
                chk("burst_rdata", o_resp_rdata, wr ? 32'h0 : (fresh ? 32'h5A5A5A5A : pat(k - 1)));
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        chk("burst_idle", o_resp_valid, 1'b0);
    endtask

    initial begin
        i_nrst = 1'b0;
        i_clear = 1'b0;
        i_resp_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        #3;
        chk("rst_init_done", o_init_done, 1'b0);
        chk("rst_req_ready", o_req_ready, 1'b0);
        chk("rst_resp_valid", o_resp_valid, 1'b0);
        chk("rst_resp_write", o_resp_write, 1'b0);
        chk("rst_resp_rdata", o_resp_rdata, 32'h0);
        tick();
        tick();
        i_nrst = 1'b1;
        wait_sweep("sweep1");
        // every address reads back the init value, one response per cycle
        burst(1'b0, 1'b1);
        burst(1'b1, 1'b0);
        burst(1'b0, 1'b0);
        // lane merge and read right after write
        drive(1, 1, 4'd3, 4'b1111, 32'hAABBCCDD);
        #1;
        chk("bwe_ready", o_req_ready, 1'b1);
        tick();
        drive(1, 1, 4'd3, 4'b0101, 32'h11223344);
        #1;
        chk("bwe_wr1_write", o_resp_write, 1'b1);
        chk("bwe_wr1_rdata", o_resp_rdata, 32'h0);
        tick();
        drive(1, 0, 4'd3, 4'b0000, 32'h0);
        #1;
        chk("bwe_wr2_valid", o_resp_valid, 1'b1);
        chk("bwe_wr2_write", o_resp_write, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("bwe_rd_valid", o_resp_valid, 1'b1);
        chk("bwe_rd_write", o_resp_write, 1'b0);
        chk("bwe_rd_rdata", o_resp_rdata, 32'hAA22CC44);
        tick();
        chk("bwe_idle", o_resp_valid, 1'b0);
        // backpressure: two accepted, then stall until the consumer is ready
        i_resp_ready = 1'b0;
        drive(1, 0, 4'd5, 0, 0);
        #1;
        chk("bp_ready0", o_req_ready, 1'b1);
        tick();
        drive(1, 0, 4'd6, 0, 0);
        #1;
        chk("bp_ready1", o_req_ready, 1'b1);
        tick();
        drive(1, 0, 4'd7, 0, 0);
        #1;
        chk("bp_full_ready", o_req_ready, 1'b0);
        chk("bp_head_rdata", o_resp_rdata, pat(5));
        tick();
        chk("bp_still_full", o_req_ready, 1'b0);
        chk("bp_still_valid", o_resp_valid, 1'b1);
        i_resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", o_req_ready, 1'b1);
        chk("bp_resp5", o_resp_rdata, pat(5));
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("bp_resp6_valid", o_resp_valid, 1'b1);
        chk("bp_resp6", o_resp_rdata, pat(6));
        tick();
        chk("bp_resp7_valid", o_resp_valid, 1'b1);
        chk("bp_resp7", o_resp_rdata, pat(7));
        tick();
        chk("bp_drained", o_resp_valid, 1'b0);
        // clear coincident with an accepted read: the read completes, then the sweep reruns
        drive(1, 0, 4'd9, 0, 0);
        i_clear = 1'b1;
        #1;
        chk("clr_accept", o_req_ready, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0);
        i_clear = 1'b0;
        #1;
        chk("clr_inflight_valid", o_resp_valid, 1'b1);
        chk("clr_inflight_rdata", o_resp_rdata, pat(9));
        chk("clr_pend_ready", o_req_ready, 1'b0);
        tick();
        chk("clr_init_low", o_init_done, 1'b0);
        chk("clr_resp_gone", o_resp_valid, 1'b0);
        wait_sweep("sweep2");
        drive(1, 0, 4'd9, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("clr_read_valid", o_resp_valid, 1'b1);
        chk("clr_read_rdata", o_resp_rdata, 32'h5A5A5A5A);
        tick();
        // reset mid-stream with responses pending
        drive(1, 1, 4'd2, 4'hF, 32'hDEADBEEF);
        tick();
        i_resp_ready = 1'b0;
        drive(1, 0, 4'd2, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("rst6_pending_valid", o_resp_valid, 1'b1);
        chk("rst6_pending_write", o_resp_write, 1'b1);
        i_nrst = 1'b0;
        #1;
        chk("rst6_init_done", o_init_done, 1'b0);
        chk("rst6_req_ready", o_req_ready, 1'b0);
        chk("rst6_resp_valid", o_resp_valid, 1'b0);
        chk("rst6_resp_write", o_resp_write, 1'b0);
        chk("rst6_resp_rdata", o_resp_rdata, 32'h0);
        tick();
        i_nrst = 1'b1;
        i_resp_ready = 1'b1;
        wait_sweep("sweep3");
        drive(1, 0, 4'd2, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("rst6_read_write", o_resp_write, 1'b0);
        chk("rst6_read_rdata", o_resp_rdata, 32'h5A5A5A5A);
        tick();
        chk("rst6_idle", o_resp_valid, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
